// File: rtl/fixed_matmul_pkg.sv
// Shared constants and width helpers for the fixed-point matrix-multiply core.
package fixed_matmul_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    function automatic int acc_width(input int in1_width, input int in2_width,
                                     input int in_size, input int in_depth,
                                     input int has_bias);
        return in1_width + in2_width + $clog2(in_size * in_depth) + has_bias;
    endfunction

    // Left shift that moves a value from src_frac fractional bits to dst_frac.
    function automatic int align_shift(input int dst_frac, input int src_frac);
        return dst_frac - src_frac;
    endfunction

    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fixed_matmul_acc_core_round_sat.sv
// One output lane: rescale an accumulator value to the output format with
// optional half-up rounding and optional clamping.
module fixed_round_sat
    import fixed_matmul_pkg::*;
#(
    parameter int ACC_WIDTH      = 18,
    parameter int ACC_FRAC_WIDTH = 8,
    parameter int OUT_WIDTH      = 8,
    parameter int OUT_FRAC_WIDTH = 4,
    parameter int ROUND_MODE     = ROUND_TRUNC,
    parameter int SATURATE       = 1
) (
    input  logic signed [ACC_WIDTH-1:0] acc_val,
    output logic        [OUT_WIDTH-1:0] out_val,
    output logic                        sat
);

    // One guard bit so the rounding increment can never wrap.
    localparam int W       = ACC_WIDTH + 1;
    localparam int S       = align_shift(ACC_FRAC_WIDTH, OUT_FRAC_WIDTH);
    localparam int RND_POS = (S > 0) ? S - 1 : 0;
    localparam logic signed [W-1:0] RND =
        (ROUND_MODE == ROUND_HALF_UP && S > 0) ? (W'(1) << RND_POS) : W'(0);
    localparam logic signed [W-1:0] MAX_V = W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [W-1:0] MIN_V = W'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    logic signed [W-1:0] ext;
    logic signed [W-1:0] biased;
    logic signed [W-1:0] shifted;

    always_comb begin
        ext     = {acc_val[ACC_WIDTH-1], acc_val};
        biased  = ext + RND;
        shifted = biased >>> S;
        out_val = shifted[OUT_WIDTH-1:0];
        sat     = 1'b0;
        if (SATURATE != 0) begin
            if (shifted > MAX_V) begin
                out_val = MAX_V[OUT_WIDTH-1:0];
                sat     = 1'b1;
            end else if (shifted < MIN_V) begin
                out_val = MIN_V[OUT_WIDTH-1:0];
                sat     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fixed_matmul_acc_core.sv
// Streaming fixed-point matmul tile: joins in1/in2 beats, accumulates over
// IN_DEPTH beats, adds bias on the last one and holds the result in a
// back-pressured output register.
module fixed_matmul_acc_core
    import fixed_matmul_pkg::*;
#(
    parameter int IN1_WIDTH       = 8,
    parameter int IN1_FRAC_WIDTH  = 4,
    parameter int IN2_WIDTH       = 8,
    parameter int IN2_FRAC_WIDTH  = 4,
    parameter int BIAS_WIDTH      = 8,
    parameter int BIAS_FRAC_WIDTH = 4,
    parameter int OUT_WIDTH       = 8,
    parameter int OUT_FRAC_WIDTH  = 4,
    parameter int IN1_PARALLELISM = 2,
    parameter int IN_SIZE         = 2,
    parameter int IN2_PARALLELISM = 2,
    parameter int IN_DEPTH        = 2,
    parameter int HAS_BIAS        = 0,
    parameter int ROUND_MODE      = ROUND_TRUNC,
    parameter int SATURATE        = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [IN1_PARALLELISM*IN_SIZE-1:0][IN1_WIDTH-1:0]   data_in1,
    input  logic                                                 data_in1_valid,
    output logic                                                 data_in1_ready,
    input  logic [IN_SIZE*IN2_PARALLELISM-1:0][IN2_WIDTH-1:0]   data_in2,
    input  logic                                                 data_in2_valid,
    output logic                                                 data_in2_ready,
    input  logic [IN1_PARALLELISM*IN2_PARALLELISM-1:0][BIAS_WIDTH-1:0] bias,
    input  logic                                                 bias_valid,
    output logic                                                 bias_ready,
    output logic [IN1_PARALLELISM*IN2_PARALLELISM-1:0][OUT_WIDTH-1:0] data_out,
    output logic                                                 data_out_valid,
    input  logic                                                 data_out_ready,
    output logic                                                 sat_flag
);

    localparam int ROWS           = IN1_PARALLELISM;
    localparam int COLS           = IN2_PARALLELISM;
    localparam int LANES          = ROWS * COLS;
    localparam int ACC_WIDTH      = acc_width(IN1_WIDTH, IN2_WIDTH, IN_SIZE, IN_DEPTH, HAS_BIAS);
    localparam int ACC_FRAC_WIDTH = IN1_FRAC_WIDTH + IN2_FRAC_WIDTH;
    localparam int BIAS_SHIFT     = align_shift(ACC_FRAC_WIDTH, BIAS_FRAC_WIDTH);
    localparam int PROD_W         = IN1_WIDTH + IN2_WIDTH;
    localparam int CNT_W          = cnt_width(IN_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

    logic [CNT_W-1:0]            depth_cnt;
    logic                        out_full;
    logic signed [ACC_WIDTH-1:0] acc       [LANES];
    logic signed [ACC_WIDTH-1:0] acc_next  [LANES];
    logic signed [ACC_WIDTH-1:0] final_sum [LANES];
    logic [LANES-1:0][OUT_WIDTH-1:0] rounded;
    logic [LANES-1:0]            lane_sat;

    logic last;
    logic hold_out;
    logic can_accept;
    logic accept;
    logic load;

    // Handshake: a beat moves only when both inputs are valid in the same cycle
    // and can_accept is high; each ready is can_accept gated by the other
    // stream's valid, so neither stream is ever consumed alone. On the last
    // beat the output register must be free (or draining) and, with bias
    // enabled, the bias must be present; bias_ready pulses with that beat.
    assign last           = (depth_cnt == LAST_CNT);
    assign hold_out       = out_full && !data_out_ready;
    assign can_accept     = rst && !(last && hold_out) && !(last && (HAS_BIAS != 0) && !bias_valid);
    assign data_in1_ready = can_accept && data_in2_valid;
    assign data_in2_ready = can_accept && data_in1_valid;
    assign bias_ready     = (HAS_BIAS != 0) && rst && last && data_in1_valid &&
                            data_in2_valid && !hold_out;
    assign accept         = data_in1_valid && data_in2_valid && can_accept;
    assign load           = accept && last;
    assign data_out_valid = out_full;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic signed [PROD_W-1:0]    prod;
                logic signed [ACC_WIDTH-1:0] sum;
                sum = acc[r*COLS+c];
                for (int k = 0; k < IN_SIZE; k++) begin
                    prod = $signed(data_in1[r*IN_SIZE+k]) * $signed(data_in2[k*COLS+c]);
                    sum  = sum + ACC_WIDTH'(prod);
                end
                acc_next[r*COLS+c]  = sum;
                final_sum[r*COLS+c] = sum;
                if (HAS_BIAS != 0) begin
                    final_sum[r*COLS+c] = sum +
                        (ACC_WIDTH'($signed(bias[r*COLS+c])) <<< BIAS_SHIFT);
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fixed_round_sat #(
            .ACC_WIDTH      (ACC_WIDTH),
            .ACC_FRAC_WIDTH (ACC_FRAC_WIDTH),
            .OUT_WIDTH      (OUT_WIDTH),
            .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH),
            .ROUND_MODE     (ROUND_MODE),
            .SATURATE       (SATURATE)
        ) u_round_sat (
            .acc_val (final_sum[l]),
            .out_val (rounded[l]),
            .sat     (lane_sat[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            depth_cnt <= '0;
            out_full  <= 1'b0;
            sat_flag  <= 1'b0;
            data_out  <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else begin
            if (accept) begin
                if (last) begin
                    depth_cnt <= '0;
                    for (int l = 0; l < LANES; l++) acc[l] <= '0;
                end else begin
                    depth_cnt <= depth_cnt + 1'b1;
                    for (int l = 0; l < LANES; l++) acc[l] <= acc_next[l];
                end
            end
            // A load wins over a drain in the same cycle, so out_full stays set.
            if (load) begin
                data_out <= rounded;
                out_full <= 1'b1;
                sat_flag <= sat_flag | (|lane_sat);
            end else if (data_out_ready) begin
                out_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_matmul_acc_core.sv
// Randomized bench for fixed_matmul_acc_core: four parameter variants share one
// stimulus stream and are checked against a plain-arithmetic tile model.
module tb_fixed_matmul_acc_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][7:0] d1, d2, bias_d;
  logic            beat_valid;
  logic [3:0]      pending;
  logic            bias_valid;
  logic            out_ready;
  logic [3:0]      vin, rdy1, rdy2, brdy, ovalid, satf;
  logic [3:0][7:0] dout [4];

  assign vin = pending & {4{beat_valid}};

  // 0: defaults, 1: wrap, 2: round half up, 3: bias
  fixed_matmul_acc_core u_dut0 (
    .clk(clk), .rst(rst),
    .data_in1(d1), .data_in1_valid(vin[0]), .data_in1_ready(rdy1[0]),
    .data_in2(d2), .data_in2_valid(vin[0]), .data_in2_ready(rdy2[0]),
    .bias(bias_d), .bias_valid(bias_valid), .bias_ready(brdy[0]),
    .data_out(dout[0]), .data_out_valid(ovalid[0]), .data_out_ready(out_ready),
    .sat_flag(satf[0]));

  fixed_matmul_acc_core #(.SATURATE(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .data_in1(d1), .data_in1_valid(vin[1]), .data_in1_ready(rdy1[1]),
    .data_in2(d2), .data_in2_valid(vin[1]), .data_in2_ready(rdy2[1]),
    .bias(bias_d), .bias_valid(bias_valid), .bias_ready(brdy[1]),
    .data_out(dout[1]), .data_out_valid(ovalid[1]), .data_out_ready(out_ready),
    .sat_flag(satf[1]));

  fixed_matmul_acc_core #(.ROUND_MODE(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .data_in1(d1), .data_in1_valid(vin[2]), .data_in1_ready(rdy1[2]),
    .data_in2(d2), .data_in2_valid(vin[2]), .data_in2_ready(rdy2[2]),
    .bias(bias_d), .bias_valid(bias_valid), .bias_ready(brdy[2]),
    .data_out(dout[2]), .data_out_valid(ovalid[2]), .data_out_ready(out_ready),
    .sat_flag(satf[2]));

  fixed_matmul_acc_core #(.HAS_BIAS(1)) u_dut3 (
    .clk(clk), .rst(rst),
    .data_in1(d1), .data_in1_valid(vin[3]), .data_in1_ready(rdy1[3]),
    .data_in2(d2), .data_in2_valid(vin[3]), .data_in2_ready(rdy2[3]),
    .bias(bias_d), .bias_valid(bias_valid), .bias_ready(brdy[3]),
    .data_out(dout[3]), .data_out_valid(ovalid[3]), .data_out_ready(out_ready),
    .sat_flag(satf[3]));

  int total = 0;
  int bad = 0;
  int bias_hs = 0;
  int bias_hold = 0;
  int ready_hold = 0;
  bit rand_mode = 0;
  bit bias_check = 0;
  bit stall_check = 0;

  longint      macc [4][4];
  int          mcnt [4];
  bit          exp_sat [4];
  logic [31:0] exp_q [4][$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int l = 0; l < 4; l++) macc[i][l] = 0;
      mcnt[i] = 0;
      exp_sat[i] = 0;
      exp_q[i].delete();
    end
  endtask

  // out[r][c] = sum_d sum_k in1[r][k]*in2[k][c] (+bias), scaled from 8 to 4 frac bits
  task automatic model_beat(input int i, input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                            input logic [3:0][7:0] bv);
    logic [31:0] w;
    longint v;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 2; k++)
          macc[i][r*2+c] += longint'($signed(a[r*2+k])) * longint'($signed(b[k*2+c]));
    mcnt[i]++;
    if (mcnt[i] == 2) begin
      w = '0;
      for (int l = 0; l < 4; l++) begin
        v = macc[i][l];
        if (i == 3) v += longint'($signed(bv[l])) * 16;
        if (i == 2) v += 8;
        v = v >>> 4;
        if (i != 1) begin
          if (v > 127) begin v = 127; exp_sat[i] = 1; end
          else if (v < -128) begin v = -128; exp_sat[i] = 1; end
        end
        w[l*8 +: 8] = v[7:0];
        macc[i][l] = 0;
      end
      mcnt[i] = 0;
      exp_q[i].push_back(w);
    end
  endtask

  task automatic send_beat(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                           input logic [3:0][7:0] bv);
    logic [3:0] took;
    d1 = a; d2 = b; bias_d = bv;
    pending = 4'hF;
    beat_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && pending != 4'h0; cyc++) begin
      if (bias_hold > 0) begin bias_valid = 1'b0; bias_hold--; end
      else if (rand_mode) bias_valid = 1'($urandom_range(0, 1));
      else bias_valid = 1'b1;
      if (ready_hold > 0) begin out_ready = 1'b0; ready_hold--; end
      else if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      @(negedge clk);
      took = pending & rdy1;
      if (stall_check && !out_ready) check_val("bp_stall_ready", 32'(rdy1 | rdy2), 32'h0);
      if (bias_check && !bias_valid) check_val("bias_stall_ready", 32'(rdy1[3] | rdy2[3]), 32'h0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (took[i]) model_beat(i, a, b, bv);
      pending = pending & ~took;
    end
    if (pending != 4'h0) check_val("beat_timeout", 32'(pending), 32'h0);
    pending = 4'h0;
    beat_valid = 1'b0;
  endtask

  task automatic send_tile(input logic [3:0][7:0] a0, input logic [3:0][7:0] b0,
                           input logic [3:0][7:0] a1, input logic [3:0][7:0] b1,
                           input logic [3:0][7:0] bv);
    send_beat(a0, b0, bv);
    send_beat(a1, b1, bv);
  endtask

  // Scoreboard: every valid cycle the held tile must equal the queue head.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (brdy[3] && bias_valid) bias_hs++;
      for (int i = 0; i < 4; i++) begin
        if (ovalid[i]) begin
          if (exp_q[i].size() == 0) begin
            check_val($sformatf("unexpected_out%0d", i), 32'(ovalid[i]), 32'h0);
          end else begin
            check_val($sformatf("out%0d", i), dout[i], exp_q[i][0]);
            check_val($sformatf("sat%0d", i), 32'(satf[i]), 32'(exp_sat[i]));
            if (out_ready) void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0][7:0] ones, zeros, r0, r1, r2, r3;
    ones  = {4{8'h10}};
    zeros = '0;
    d1 = '0; d2 = '0; bias_d = {4{8'h08}};
    beat_valid = 1'b1; pending = 4'hF;
    bias_valid = 1'b1; out_ready = 1'b1;
    model_reset();

    // reset: readies stay low even with valids up
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 32'(rdy1 | rdy2 | brdy), 32'h0);
    @(posedge clk); #1;
    beat_valid = 1'b0; pending = 4'h0;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_valid", 32'(ovalid), 32'h0);
    check_val("rst_sat", 32'(satf), 32'h0);
    check_val("rst_dout", dout[0], 32'h0);
    @(posedge clk); #1;

    // ones tile: one output the cycle after the last beat
    send_tile(ones, ones, ones, ones, {4{8'h08}});
    check_val("lat_valid", 32'(ovalid), 32'hF);
    check_val("ones_dout", dout[0], 32'h40404040);
    check_val("ones_bias", dout[3], 32'h48484848);
    check_val("ones_sat", 32'(satf), 32'h0);

    // positive saturation
    send_tile({4{8'h7F}}, {4{8'h7F}}, {4{8'h7F}}, {4{8'h7F}}, zeros);
    check_val("pos_sat_dout", dout[0], 32'h7F7F7F7F);
    check_val("pos_wrap_dout", dout[1], 32'hC0C0C0C0);
    check_val("pos_sat_flag", 32'(satf), 32'hD);

    // negative saturation
    send_tile({4{8'h80}}, {4{8'h7F}}, {4{8'h80}}, {4{8'h7F}}, zeros);
    check_val("neg_sat_dout", dout[0], 32'h80808080);
    check_val("neg_wrap_dout", dout[1], 32'h20202020);

    // half-LSB rounding
    send_tile(32'h00000001, 32'h00000008, zeros, zeros, zeros);
    check_val("trunc_lane0", 32'(dout[0][0]), 32'h00);
    check_val("round_lane0", 32'(dout[2][0]), 32'h01);

    // bias held back on the last beat
    send_beat(ones, ones, {4{8'h08}});
    bias_hs = 0;
    bias_hold = 4;
    bias_check = 1;
    send_beat(ones, ones, {4{8'h08}});
    bias_check = 0;
    check_val("bias_dout", dout[3], 32'h48484848);
    check_val("bias_hs", 32'(bias_hs), 32'h1);

    // back-pressure: output held while the next tile stalls on its last beat
    r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    ready_hold = 8;
    send_tile(r0, r1, r2, r3, zeros);
    r0 = $urandom; r1 = $urandom;
    send_beat(r0, r1, zeros);
    stall_check = 1;
    r2 = $urandom; r3 = $urandom;
    send_beat(r2, r3, zeros);
    stall_check = 0;
    r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    send_tile(r0, r1, r2, r3, zeros);

    // random data, random bias_valid and output ready
    rand_mode = 1;
    repeat (20) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      send_tile(r0, r1, r2, r3, 32'($urandom));
    end
    rand_mode = 0;

    // reset mid-tile discards the partial sum
    send_beat(ones, ones, {4{8'h08}});
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_valid", 32'(ovalid), 32'h0);
    check_val("midrst_sat", 32'(satf), 32'h0);
    @(posedge clk); #1;
    send_tile(ones, ones, ones, ones, {4{8'h08}});
    check_val("post_rst_dout", dout[0], 32'h40404040);

    // drain everything still expected
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(posedge clk); #1;
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0 && exp_q[3].size() == 0 && ovalid == 4'h0) break;
    end
    for (int i = 0; i < 4; i++)
      check_val($sformatf("drain%0d", i), 32'(exp_q[i].size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_matmul_acc_core.md
Name: fixed_matmul_acc_core

Overview:
- Next-generation streaming fixed-point matrix-multiply core. It computes an output tile of OUT_ROWS x OUT_COLUMNS, where out[r][c] = sum over d, k of in1[r][k] * in2[k][c] (+ bias[r][c]).
- It accumulates internally over IN_DEPTH input beats.
- Adds over the previous generation: a registered, back-pressured output stage, selectable rounding mode, saturation with a sticky overflow flag, and bias consumed only on the last beat.
- Sits between the weight/activation buffers and the downstream activation/cast stage of linear and attention layers.

Parameters:
- IN1_WIDTH, 8, total bits of in1 elements (signed).
- IN1_FRAC_WIDTH, 4, fractional bits of in1.
- IN2_WIDTH, 8, total bits of in2 elements (signed).
- IN2_FRAC_WIDTH, 4, fractional bits of in2.
- BIAS_WIDTH, 8, total bits of bias elements (signed).
- BIAS_FRAC_WIDTH, 4, fractional bits of bias; must be <= ACC_FRAC_WIDTH.
- OUT_WIDTH, 8, total bits of output elements (signed).
- OUT_FRAC_WIDTH, 4, fractional bits of output; must be <= ACC_FRAC_WIDTH.
- IN1_PARALLELISM, 2, output rows per tile (OUT_ROWS).
- IN_SIZE, 2, reduction elements per beat.
- IN2_PARALLELISM, 2, output columns per tile (OUT_COLUMNS).
- IN_DEPTH, 2, beats accumulated per tile; must be >= 1.
- HAS_BIAS, 0, 1 = add bias on the last beat.
- ROUND_MODE, 0, 0 = truncate (floor), 1 = round half up.
- SATURATE, 1, 1 = clamp to the output range, 0 = wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- data_in1  in  IN1_WIDTH x (IN1_PARALLELISM*IN_SIZE)  row-major in1 block, index r*IN_SIZE+k.
- data_in1_valid  in  1  in1 valid.
- data_in1_ready  out  1  in1 ready.
- data_in2  in  IN2_WIDTH x (IN_SIZE*IN2_PARALLELISM)  row-major in2 block, index k*IN2_PARALLELISM+c.
- data_in2_valid  in  1  in2 valid.
- data_in2_ready  out  1  in2 ready.
- bias  in  BIAS_WIDTH x (OUT_ROWS*OUT_COLUMNS)  index r*OUT_COLUMNS+c.
- bias_valid  in  1  bias valid.
- bias_ready  out  1  bias ready.
- data_out  out  OUT_WIDTH x (OUT_ROWS*OUT_COLUMNS)  result tile.
- data_out_valid  out  1  result valid.
- data_out_ready  in  1  downstream ready.
- sat_flag  out  1  sticky: at least one output element has been clamped since reset.

Behaviour:
- Widths:
  - ACC_WIDTH = IN1_WIDTH + IN2_WIDTH + clog2(IN_SIZE*IN_DEPTH) + HAS_BIAS.
  - ACC_FRAC_WIDTH = IN1_FRAC_WIDTH + IN2_FRAC_WIDTH.
  - All arithmetic is signed, and the accumulator never overflows.
- Join:
  - A beat is accepted when data_in1_valid && data_in2_valid && can_accept.
  - Both readies equal can_accept && the other input's valid. Neither stream is consumed alone.
- Last beat: the beat where depth_cnt == IN_DEPTH-1.
  - can_accept = !(last && out_full && !data_out_ready) && !(last && HAS_BIAS && !bias_valid).
  - bias_ready = HAS_BIAS && last && data_in1_valid && data_in2_valid && !(out_full && !data_out_ready). This is asserted only in the same cycle the last beat is accepted.
  - HAS_BIAS=0: bias_ready is held 0 and the bias port is ignored.
- Accumulate:
  - On an accepted beat that is not last: acc += sum of the products, and depth_cnt increments.
  - On the last beat: the final sum is acc + beat products + aligned bias. The bias is sign-extended and shifted left by ACC_FRAC_WIDTH - BIAS_FRAC_WIDTH.
  - The final sum is rounded/saturated and loaded into the output register. acc is cleared, depth_cnt returns to 0, and out_full is set.
- IN_DEPTH=1: every beat is a last beat.
- Latency: data_out_valid rises the cycle after the last beat is accepted.
- Throughput: one beat per cycle while the output drains. The next tile accumulates while the output register is still held.
- Output register:
  - data_out_valid = out_full.
  - data_out is stable while valid && !ready.
  - The output clears when data_out_ready is high and no new tile is loaded.
  - A simultaneous drain and load in the same cycle keeps out_full = 1 with the new data.
- Rounding: shift s = ACC_FRAC_WIDTH - OUT_FRAC_WIDTH.
  - ROUND_MODE 0: arithmetic right shift by s.
  - ROUND_MODE 1: add 2^(s-1) before the shift (s=0: no add).
- Saturation:
  - SATURATE=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Any clamped lane sets sat_flag in the load cycle.
  - SATURATE=0: keep the low OUT_WIDTH bits; sat_flag stays 0.
- Reset (rst=0 at a clock edge):
  - acc = 0, depth_cnt = 0, out_full = 0, sat_flag = 0, data_out = 0. All readies are low during reset.
  - Reset mid-tile discards the partial accumulation and the held output.

Decomposition:
- Package fixed_matmul_pkg holds:
  - a function for ACC_WIDTH;
  - localparam helpers for alignment shifts;
  - the ROUND_MODE encodings ROUND_TRUNC = 0 and ROUND_HALF_UP = 1.
- Sub-module fixed_round_sat: purely combinational, one lane. It takes ACC_WIDTH/ACC_FRAC_WIDTH in and produces OUT_WIDTH/OUT_FRAC_WIDTH plus a sat bit, and is instantiated OUT_ROWS*OUT_COLUMNS times.
- Counter, join and output register stay in the top level.

Test Plan:
- Defaults, all in1 = 0x10 and all in2 = 0x10 for 2 beats -> one output after 1 cycle, all four lanes = 0x40, sat_flag = 0.
- All in1 = 0x7F and in2 = 0x7F (x2 beats) -> lanes = 0x7F, sat_flag = 1.
- in1 = 0x80 and in2 = 0x7F -> lanes = 0x80, sat_flag = 1.
- SATURATE = 0, same stimulus -> lanes equal the low 8 bits of the wrapped value, sat_flag = 0.
- Half-LSB rounding: in1[0] = 0x01 and in2[0] = 0x08 on beat 0, everything else 0 -> ROUND_MODE 0 gives lane0 = 0x00; ROUND_MODE 1 gives lane0 = 0x01.
- HAS_BIAS = 1, bias = 0x08 everywhere, ones stimulus:
  - bias_valid held low -> last beat stalls with readies low;
  - raising bias_valid -> accepted, lanes = 0x48;
  - bias_ready high for exactly one cycle.
- Back-pressure: data_out_ready = 0 for 5 cycles with 3 tiles queued -> data_out is stable, the second tile accumulates then stalls on its last beat, no tile is lost or duplicated, and the order is preserved.
- Assert rst = 0 after beat 0 of a tile -> no output; the next full tile gives a clean 0x40.
